// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and limits for the multi-slot alarm clock
package alarm_pkg;

  localparam logic [7:0] MAX_SEC  = 8'd59;
  localparam logic [7:0] MAX_MIN  = 8'd59;
  localparam logic [7:0] MAX_HOUR = 8'd23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_e;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } hms_t;

  function automatic logic hms_in_range(input hms_t t);
    return (t.hour <= MAX_HOUR) && (t.min <= MAX_MIN) && (t.sec <= MAX_SEC);
  endfunction

endpackage

// File: rtl/hms_counter.sv
// rtl/hms_counter.sv - seconds prescaler and hh:mm:ss carry chain with load port
module hms_counter
  import alarm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_valid,
  input  hms_t load_time,
  output hms_t cur_time,
  output logic tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pre_q, pre_d;
  hms_t          time_q, time_d;
  logic          raw_tick;

  always_comb begin
    raw_tick = (pre_q == PRE_LAST);
    pre_d    = pre_q + 1'b1;
    time_d   = time_q;
    if (load_valid) begin
      pre_d  = '0;
      time_d = load_time;
    end else if (raw_tick) begin
      pre_d = '0;
      if (time_q.sec == MAX_SEC) begin
        time_d.sec = '0;
        if (time_q.min == MAX_MIN) begin
          time_d.min  = '0;
          time_d.hour = (time_q.hour == MAX_HOUR) ? 8'd0 : time_q.hour + 8'd1;
        end else begin
          time_d.min = time_q.min + 8'd1;
        end
      end else begin
        time_d.sec = time_q.sec + 8'd1;
      end
    end
  end

  // A load swallows the coincident tick so downstream counters never see it.
  assign tick     = raw_tick && !load_valid;
  assign cur_time = time_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      time_q <= '0;
    end else begin
      pre_q  <= pre_d;
      time_q <= time_d;
    end
  end

endmodule

// File: rtl/alarm_clock_multi.sv
// rtl/alarm_clock_multi.sv - time-of-day clock with N alarm slots, snooze and auto-stop
module alarm_clock_multi
  import alarm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int NUM_ALARMS    = 4,
  parameter int SNOOZE_SEC    = 300,
  parameter int RING_SEC      = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [3:0]            set_sel,
  input  logic [7:0]            set_hour,
  input  logic [7:0]            set_min,
  input  logic [7:0]            set_sec,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  stop,
  output logic [7:0]            hour,
  output logic [7:0]            min,
  output logic [7:0]            sec,
  output logic                  ring,
  output logic [2:0]            ring_id,
  output logic                  snoozing,
  output logic                  set_err
);

  localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC + 1) : 1;
  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  hms_t                  set_val;
  hms_t                  cur_time;
  logic                  set_ok;
  logic                  time_load;
  logic                  tick;

  hms_t                  alarm_q [NUM_ALARMS];
  hms_t                  alarm_d [NUM_ALARMS];
  alarm_state_e          state_q, state_d;
  logic [2:0]            ring_id_q, ring_id_d;
  logic [SW-1:0]         snz_q, snz_d;
  logic [RW-1:0]         rc_q, rc_d;
  logic                  eval_q, eval_d;
  logic                  set_err_q, set_err_d;

  logic [NUM_ALARMS-1:0] hit;
  logic                  match;
  logic [2:0]            match_id;
  logic [7:0]            en_ext;
  logic                  ring_en;

  assign set_val   = {set_hour, set_min, set_sec};
  assign set_ok    = set_valid && hms_in_range(set_val) && (set_sel <= 4'(NUM_ALARMS));
  assign time_load = set_ok && (set_sel == 4'd0);

  hms_counter #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_hms (
    .clk       (clk),
    .rst       (rst),
    .load_valid(time_load),
    .load_time (set_val),
    .cur_time  (cur_time),
    .tick      (tick)
  );

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      alarm_d[i] = alarm_q[i];
      if (set_ok && (set_sel == 4'(i + 1))) alarm_d[i] = set_val;
    end
  end

  // Matches are only meaningful in the cycle right after the time moved.
  always_comb begin
    match_id = 3'd0;
    for (int i = 0; i < NUM_ALARMS; i++) hit[i] = alarm_en[i] && (alarm_q[i] == cur_time);
    for (int i = NUM_ALARMS - 1; i >= 0; i--) if (hit[i]) match_id = 3'(i);
    match = eval_q && (|hit);
  end

  assign en_ext  = 8'(alarm_en);
  assign ring_en = en_ext[ring_id_q];

  always_comb begin
    state_d   = state_q;
    ring_id_d = ring_id_q;
    snz_d     = snz_q;
    rc_d      = rc_q;
    eval_d    = tick || time_load;
    set_err_d = set_valid && !set_ok;
    case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d   = ST_RING;
          ring_id_d = match_id;
          rc_d      = '0;
        end
      end
      ST_RING: begin
        if (stop || !ring_en) begin
          state_d = ST_IDLE;
          rc_d    = '0;
        end else if (snooze) begin
          state_d = ST_SNOOZE;
          snz_d   = SW'(SNOOZE_SEC);
          rc_d    = '0;
        end else if (tick) begin
          if (rc_q == RW'(RING_SEC - 1)) begin
            state_d = ST_IDLE;
            rc_d    = '0;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (stop || !ring_en) begin
          state_d = ST_IDLE;
          snz_d   = '0;
        end else if (match) begin
          state_d   = ST_RING;
          ring_id_d = match_id;
          snz_d     = '0;
          rc_d      = '0;
        end else if (tick) begin
          if (snz_q <= SW'(1)) begin
            state_d = ST_RING;
            snz_d   = '0;
            rc_d    = '0;
          end else begin
            snz_d = snz_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= '0;
      state_q   <= ST_IDLE;
      ring_id_q <= '0;
      snz_q     <= '0;
      rc_q      <= '0;
      eval_q    <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= alarm_d[i];
      state_q   <= state_d;
      ring_id_q <= ring_id_d;
      snz_q     <= snz_d;
      rc_q      <= rc_d;
      eval_q    <= eval_d;
      set_err_q <= set_err_d;
    end
  end

  assign hour     = cur_time.hour;
  assign min      = cur_time.min;
  assign sec      = cur_time.sec;
  assign ring     = (state_q == ST_RING);
  assign snoozing = (state_q == ST_SNOOZE);
  assign ring_id  = ring_id_q;
  assign set_err  = set_err_q;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// tb/tb_alarm_clock_multi.sv - directed scenarios plus randomized run against a seconds-of-day model
module tb_alarm_clock_multi;

  localparam int TPS  = 4;
  localparam int NA   = 2;
  localparam int SNZ  = 3;
  localparam int RSEC = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          set_valid;
  logic [3:0]    set_sel;
  logic [7:0]    set_hour, set_min, set_sec;
  logic [NA-1:0] alarm_en;
  logic          snooze, stop;
  logic [7:0]    hour, min, sec;
  logic          ring;
  logic [2:0]    ring_id;
  logic          snoozing, set_err;

  int total = 0;
  int bad   = 0;

  // reference model state: time as seconds of day, mode 0=idle 1=ring 2=snooze
  int m_t, m_pre, m_st, m_id, m_snz, m_rc;
  int m_al [NA];
  bit m_eval, m_err;

  always #5 clk = ~clk;

  alarm_clock_multi #(
    .TICKS_PER_SEC(TPS),
    .NUM_ALARMS   (NA),
    .SNOOZE_SEC   (SNZ),
    .RING_SEC     (RSEC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_valid(set_valid),
    .set_sel  (set_sel),
    .set_hour (set_hour),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .alarm_en (alarm_en),
    .snooze   (snooze),
    .stop     (stop),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .ring     (ring),
    .ring_id  (ring_id),
    .snoozing (snoozing),
    .set_err  (set_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [3:0] sel, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_valid = 1'b1; set_sel = sel; set_hour = h; set_min = m; set_sec = s;
    cyc();
    set_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_valid = 1'b0; set_sel = 4'd0; set_hour = 8'd0; set_min = 8'd0; set_sec = 8'd0;
    alarm_en = '0; snooze = 1'b0; stop = 1'b0;
    cyc(); cyc();
    total++;
    if ({hour, min, sec} !== 24'h0) begin
      bad++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", hour, min, sec);
    end
    total++;
    if ({ring, ring_id, snoozing, set_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got ring=%0b id=%0d snz=%0b err=%0b want all 0", ring, ring_id, snoozing, set_err);
    end
    rst = 1'b0;
    alarm_en = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (ring !== 1'b0) begin
        bad++; $display("FAIL reset_no_ring cycle %0d got ring=%0b want 0", k, ring);
      end
    end
    alarm_en = 2'b00;
  endtask

  task automatic test_rollover();
    logic [23:0] exp;
    alarm_en = 2'b00;
    do_set(4'd0, 8'd23, 8'd59, 8'd58);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      exp = (k < 4) ? {8'd23, 8'd59, 8'd58} : (k < 8) ? {8'd23, 8'd59, 8'd59} : 24'h0;
      total++;
      if ({hour, min, sec} !== exp) begin
        bad++; $display("FAIL rollover cycle %0d got %0d:%0d:%0d want %0d:%0d:%0d", k, hour, min, sec, exp[23:16], exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_priority_match();
    alarm_en = 2'b00;
    do_set(4'd1, 8'd0, 8'd0, 8'd5);
    do_set(4'd2, 8'd0, 8'd0, 8'd5);
    do_set(4'd0, 8'd0, 8'd0, 8'd4);
    alarm_en = 2'b11;
    cyc(); cyc(); cyc(); cyc();
    total++;
    if (sec !== 8'd5 || ring !== 1'b0) begin
      bad++; $display("FAIL match_tick got sec=%0d ring=%0b want sec=5 ring=0", sec, ring);
    end
    cyc();
    total++;
    if (ring !== 1'b1 || ring_id !== 3'd0) begin
      bad++; $display("FAIL match_lowest got ring=%0b id=%0d want ring=1 id=0", ring, ring_id);
    end
  endtask

  task automatic test_snooze();
    bit got;
    snooze = 1'b1; cyc(); snooze = 1'b0;
    total++;
    if (snoozing !== 1'b1 || ring !== 1'b0) begin
      bad++; $display("FAIL snooze_enter got snz=%0b ring=%0b want snz=1 ring=0", snoozing, ring);
    end
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      cyc();
      if (ring === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || sec !== 8'd8 || ring_id !== 3'd0 || snoozing !== 1'b0) begin
      bad++; $display("FAIL snooze_expire got rang=%0b sec=%0d id=%0d snz=%0b want rang=1 sec=8 id=0 snz=0", got, sec, ring_id, snoozing);
    end
    stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
    total++;
    if (ring !== 1'b0 || snoozing !== 1'b0) begin
      bad++; $display("FAIL stop_wins got ring=%0b snz=%0b want 0 0", ring, snoozing);
    end
  endtask

  task automatic test_timeout_and_disable();
    bit dropped;
    do_set(4'd0, 8'd0, 8'd0, 8'd4);
    repeat (5) cyc();
    total++;
    if (ring !== 1'b1) begin
      bad++; $display("FAIL timeout_start got ring=%0b want 1", ring);
    end
    dropped = 1'b0;
    for (int k = 0; k < 40 && !dropped; k++) begin
      cyc();
      if (ring === 1'b0) dropped = 1'b1;
    end
    total++;
    if (!dropped || sec !== 8'd10) begin
      bad++; $display("FAIL timeout_drop got dropped=%0b sec=%0d want dropped=1 sec=10", dropped, sec);
    end
    do_set(4'd0, 8'd0, 8'd0, 8'd4);
    repeat (5) cyc();
    alarm_en = 2'b10;
    cyc();
    total++;
    if (ring !== 1'b0) begin
      bad++; $display("FAIL disable_ring got ring=%0b want 0", ring);
    end
  endtask

  task automatic test_set_err();
    alarm_en = 2'b00;
    do_set(4'd0, 8'd12, 8'd34, 8'd56);
    total++;
    if (set_err !== 1'b0) begin
      bad++; $display("FAIL err_valid_load got %0b want 0", set_err);
    end
    set_valid = 1'b1; set_sel = 4'd0; set_hour = 8'd1; set_min = 8'd60; set_sec = 8'd0;
    cyc(); set_valid = 1'b0;
    total++;
    if (set_err !== 1'b1 || {hour, min, sec} !== {8'd12, 8'd34, 8'd56}) begin
      bad++; $display("FAIL err_min60 got err=%0b time=%0d:%0d:%0d want err=1 time=12:34:56", set_err, hour, min, sec);
    end
    cyc();
    total++;
    if (set_err !== 1'b0) begin
      bad++; $display("FAIL err_one_cycle got %0b want 0", set_err);
    end
    set_valid = 1'b1; set_sel = 4'd3; set_hour = 8'd0; set_min = 8'd0; set_sec = 8'd1;
    cyc(); set_valid = 1'b0;
    total++;
    if (set_err !== 1'b1 || {hour, min, sec} !== {8'd12, 8'd34, 8'd56}) begin
      bad++; $display("FAIL err_sel3 got err=%0b time=%0d:%0d:%0d want err=1 time=12:34:56", set_err, hour, min, sec);
    end
    set_valid = 1'b1; set_sel = 4'd1; set_hour = 8'd0; set_min = 8'd0; set_sec = 8'd60;
    cyc(); set_valid = 1'b0;
    total++;
    if (set_err !== 1'b1) begin
      bad++; $display("FAIL err_alarm_sec60 got %0b want 1", set_err);
    end
    do_set(4'd0, 8'd0, 8'd0, 8'd4);
    alarm_en = 2'b01;
    repeat (5) cyc();
    total++;
    if (ring !== 1'b1 || ring_id !== 3'd0) begin
      bad++; $display("FAIL err_alarm_kept got ring=%0b id=%0d want ring=1 id=0", ring, ring_id);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_reset_in_snooze();
    alarm_en = 2'b10;
    do_set(4'd0, 8'd0, 8'd0, 8'd4);
    repeat (5) cyc();
    total++;
    if (ring !== 1'b1 || ring_id !== 3'd1) begin
      bad++; $display("FAIL rst_setup got ring=%0b id=%0d want ring=1 id=1", ring, ring_id);
    end
    snooze = 1'b1; cyc(); snooze = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    total++;
    if ({hour, min, sec, ring, ring_id, snoozing, set_err} !== 30'h0) begin
      bad++; $display("FAIL rst_in_snooze got %0d:%0d:%0d ring=%0b id=%0d snz=%0b err=%0b want all 0", hour, min, sec, ring, ring_id, snoozing, set_err);
    end
    for (int k = 0; k < 12; k++) begin
      cyc();
      total++;
      if (ring !== 1'b0 || snoozing !== 1'b0) begin
        bad++; $display("FAIL rst_no_ring cycle %0d got ring=%0b snz=%0b want 0 0", k, ring, snoozing);
      end
    end
  endtask

  task automatic model_edge();
    int hit, ld;
    bit tick, ok, tload, tick_e, en_cur;
    if (rst) begin
      m_t = 0; m_pre = 0; m_st = 0; m_id = 0; m_snz = 0; m_rc = 0; m_eval = 0; m_err = 0;
      for (int i = 0; i < NA; i++) m_al[i] = 0;
      return;
    end
    tick   = (m_pre == TPS - 1);
    ok     = set_valid && set_hour <= 23 && set_min <= 59 && set_sec <= 59 && set_sel <= NA;
    tload  = ok && set_sel == 0;
    tick_e = tick && !tload;
    ld     = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
    hit = -1;
    if (m_eval)
      for (int i = 0; i < NA; i++)
        if (hit < 0 && alarm_en[i] && m_al[i] == m_t) hit = i;
    en_cur = alarm_en[m_id];
    case (m_st)
      0: if (hit >= 0) begin m_st = 1; m_id = hit; m_rc = 0; end
      1: begin
        if (stop || !en_cur) m_st = 0;
        else if (snooze) begin m_st = 2; m_snz = SNZ; end
        else if (tick_e) begin
          m_rc++;
          if (m_rc >= RSEC) m_st = 0;
        end
      end
      default: begin
        if (stop || !en_cur) m_st = 0;
        else if (hit >= 0) begin m_st = 1; m_id = hit; m_rc = 0; end
        else if (tick_e) begin
          m_snz--;
          if (m_snz <= 0) begin m_st = 1; m_rc = 0; end
        end
      end
    endcase
    if (tload) begin m_t = ld; m_pre = 0; end
    else if (tick) begin m_t = (m_t + 1) % 86400; m_pre = 0; end
    else m_pre++;
    if (ok && set_sel != 0) m_al[set_sel - 1] = ld;
    m_eval = tick_e || tload;
    m_err  = set_valid && !ok;
  endtask

  task automatic test_random();
    logic [29:0] got, exp;
    rst = 1'b1; set_valid = 1'b0; snooze = 1'b0; stop = 1'b0; alarm_en = 2'b11;
    model_edge(); cyc();
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 499) == 0);
      set_valid = ($urandom_range(0, 9) == 0);
      set_sel   = 4'($urandom_range(0, 3));
      set_hour  = ($urandom_range(0, 7) == 0) ? 8'd24 : 8'd0;
      set_min   = ($urandom_range(0, 7) == 0) ? 8'd60 : 8'd0;
      set_sec   = 8'($urandom_range(0, 8));
      snooze    = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 39) == 0) alarm_en = 2'($urandom_range(0, 3));
      model_edge();
      cyc();
      exp = {8'(m_t / 3600), 8'((m_t / 60) % 60), 8'(m_t % 60), (m_st == 1), 3'(m_id), (m_st == 2), m_err};
      got = {hour, min, sec, ring, ring_id, snoozing, set_err};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random cycle %0d got %h want %h", n, got, exp);
      end
    end
    rst = 1'b0; set_valid = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rollover();
    test_priority_match();
    test_snooze();
    test_timeout_and_disable();
    test_set_err();
    test_reset_in_snooze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
